// File: rtl/disp_pkg.sv
// Shared constants, types and helpers for the 4-digit multiplexed BCD display scanner.
//   NUM_DIGITS : digits on the display
//   DIG_W      : bits per BCD digit
//   BCD_MAX    : largest legal BCD nibble value
//   dig_idx_t  : index of the digit currently being driven
package disp_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 4;
  localparam int BCD_MAX    = 9;

  typedef logic [1:0] dig_idx_t;

  // True when any nibble of a captured value is not a legal BCD digit.
  function automatic logic has_bad_nibble(input logic [NUM_DIGITS*DIG_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (v[k*DIG_W +: DIG_W] > DIG_W'(BCD_MAX)) bad = 1'b1;
    end
    return bad;
  endfunction

  // Active-low anode pattern with only the selected digit driven.
  function automatic logic [NUM_DIGITS-1:0] anode_mask(input dig_idx_t i);
    return ~(NUM_DIGITS'(1) << i);
  endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Slot prescaler: counts 0..SCAN_DIV-1 and raises tick while holding SCAN_DIV-1.
// With SCAN_DIV=1 the counter is stuck at 0 and tick is high every cycle.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   tick  : one-cycle pulse at the end of each digit slot
module disp_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_scan.sv
// Multiplexed 4-digit BCD display scanner with leading-zero blanking and
// invalid-digit flag. Feeds an external 7-segment decoder through data/en.
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   load     : capture bcd_in into the shadow register on this edge
//   bcd_in   : four BCD digits, [3:0] is digit 0
//   blank_lz : enable leading-zero blanking
//   data     : BCD nibble for the decoder (registered)
//   en       : decoder enable (registered)
//   dig_sel  : active-low digit anodes, bit k drives digit k (registered)
//   err      : last captured value held a nibble above 9
module disp_scan
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [NUM_DIGITS*DIG_W-1:0] bcd_in,
  input  logic                        blank_lz,
  output logic [DIG_W-1:0]            data,
  output logic                        en,
  output logic [NUM_DIGITS-1:0]       dig_sel,
  output logic                        err
);

  logic tick;

  disp_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  dig_idx_t                    idx_q, idx_d;
  logic [NUM_DIGITS*DIG_W-1:0] shadow_q, shadow_d;
  logic [DIG_W-1:0]            data_q, data_d;
  logic                        en_q, en_d;
  logic [NUM_DIGITS-1:0]       dig_sel_q, dig_sel_d;
  logic                        err_q, err_d;

  // upper_zero[k]: shadow digits k..3 are all zero.
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  blank;

  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (shadow_q[(NUM_DIGITS-1)*DIG_W +: DIG_W] == '0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (shadow_q[k*DIG_W +: DIG_W] == '0);
    end
  end

  // Digit 0 is always shown so an all-zero value still displays "0".
  assign blank = blank_lz && (idx_q != '0) && upper_zero[idx_q];

  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    err_d     = err_q;
    data_d    = shadow_q[idx_q*DIG_W +: DIG_W];
    en_d      = 1'b1;
    dig_sel_d = anode_mask(idx_q);

    if (blank) begin
      data_d    = '0;
      en_d      = 1'b0;
      dig_sel_d = '1;
    end

    if (tick) idx_d = idx_q + dig_idx_t'(1);

    if (load) begin
      shadow_d = bcd_in;
      err_d    = has_bad_nibble(bcd_in);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      dig_sel_q <= '1;
      err_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      en_q      <= en_d;
      dig_sel_q <= dig_sel_d;
      err_q     <= err_d;
    end
  end

  assign data    = data_q;
  assign en      = en_q;
  assign dig_sel = dig_sel_q;
  assign err     = err_q;

endmodule
